// File: rtl/check_state_machine_pkg.sv
// check_state_machine_pkg: cell codes, board defaults, FSM states and line helpers
package check_state_machine_pkg;
  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_P1    = 2'b01;
  localparam logic [1:0] CELL_P2    = 2'b10;
  localparam int BOARD_ROWS = 6;
  localparam int BOARD_COLS = 7;
  typedef enum logic [1:0] {IDLE, READ, EVAL, DONE} state_e;
  function automatic logic [1:0] cell_at(input logic [15:0] row, input int c);
    return row[2*c +: 2];
  endfunction
  // code 11 counts as empty, so only the two player codes can form a line
  function automatic logic line4(input logic [1:0] a, b, c, d);
    return (a == CELL_P1 || a == CELL_P2) && a == b && a == c && a == d;
  endfunction
endpackage

// File: rtl/check_state_machine_line_detect.sv
// c4_line_detect: flags any four-in-a-line across the current row and three history rows
module c4_line_detect
  import check_state_machine_pkg::*;
#(
  parameter int NUM_COLS = BOARD_COLS
) (
  input  logic [15:0] r0_i,
  input  logic [15:0] h1_i,
  input  logic [15:0] h2_i,
  input  logic [15:0] h3_i,
  input  logic        have3_i,
  output logic        win_o
);
  logic win;
  always_comb begin
    win = 1'b0;
    for (int c = 0; c <= NUM_COLS - 4; c++) begin
      win = win | line4(cell_at(r0_i, c), cell_at(r0_i, c+1), cell_at(r0_i, c+2), cell_at(r0_i, c+3));
      win = win | (have3_i & line4(cell_at(r0_i, c+3), cell_at(h1_i, c+2), cell_at(h2_i, c+1), cell_at(h3_i, c)));
      win = win | (have3_i & line4(cell_at(r0_i, c), cell_at(h1_i, c+1), cell_at(h2_i, c+2), cell_at(h3_i, c+3)));
    end
    for (int c = 0; c < NUM_COLS; c++)
      win = win | (have3_i & line4(cell_at(r0_i, c), cell_at(h1_i, c), cell_at(h2_i, c), cell_at(h3_i, c)));
  end
  assign win_o = win;
endmodule

// File: rtl/check_state_machine.sv
// check_state_machine: row-by-row Connect-4 win scan over a synchronous-read board RAM
module check_state_machine
  import check_state_machine_pkg::*;
#(
  parameter int NUM_ROWS = BOARD_ROWS,
  parameter int NUM_COLS = BOARD_COLS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        check_en,
  input  logic [15:0] ram_r_val,
  output logic [2:0]  check_addr,
  output logic        check_r_en,
  output logic        check_4,
  output logic        finished
);
  state_e      state_q;
  logic [2:0]  row_q, row_d, addr_q;
  logic [15:0] h1_q, h2_q, h3_q;
  logic        win_q, win_d, line_win, r_en_q, c4_q, fin_q, last_row;
  c4_line_detect #(.NUM_COLS(NUM_COLS)) u_detect (
    .r0_i   (ram_r_val),
    .h1_i   (h1_q),
    .h2_i   (h2_q),
    .h3_i   (h3_q),
    .have3_i(row_q >= 3'd3),
    .win_o  (line_win)
  );
  assign row_d    = row_q + 3'd1;
  assign win_d    = win_q | line_win;
  assign last_row = row_q == 3'(NUM_ROWS - 1);
  // ram_r_val is only consumed in EVAL, one cycle after the READ that addressed it
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      row_q   <= '0;
      addr_q  <= '0;
      h1_q    <= '0;
      h2_q    <= '0;
      h3_q    <= '0;
      win_q   <= 1'b0;
      r_en_q  <= 1'b0;
      c4_q    <= 1'b0;
      fin_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (check_en) begin
          state_q <= READ;
          row_q   <= '0;
          addr_q  <= '0;
          h1_q    <= '0;
          h2_q    <= '0;
          h3_q    <= '0;
          win_q   <= 1'b0;
          c4_q    <= 1'b0;
          r_en_q  <= 1'b1;
        end
        READ: begin
          state_q <= EVAL;
          r_en_q  <= 1'b0;
        end
        EVAL: begin
          win_q <= win_d;
          h3_q  <= h2_q;
          h2_q  <= h1_q;
          h1_q  <= ram_r_val;
          if (last_row) begin
            state_q <= DONE;
            fin_q   <= 1'b1;
            c4_q    <= win_d;
          end else begin
            state_q <= READ;
            row_q   <= row_d;
            addr_q  <= row_d;
            r_en_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          fin_q   <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign check_addr = addr_q;
  assign check_r_en = r_en_q;
  assign check_4    = c4_q;
  assign finished   = fin_q;
endmodule

// File: tb/tb_check_state_machine.sv
// tb_check_state_machine: directed boards, scoreboarded results and read-sequence monitor
module tb_check_state_machine;
  logic        clk = 1'b0, rst = 1'b1, check_en = 1'b0;
  logic [15:0] ram_r_val = 16'h0;
  logic [2:0]  check_addr;
  logic        check_r_en, check_4, finished;
  logic [15:0] mem [8];
  typedef struct {logic win; int fin;} exp_t;
  exp_t sb[$];
  int n_chk = 0, n_fail = 0, cyc = 0, rd_base = 0, rd_idx = 0;

  check_state_machine dut (
    .clk       (clk),
    .rst       (rst),
    .check_en  (check_en),
    .ram_r_val (ram_r_val),
    .check_addr(check_addr),
    .check_r_en(check_r_en),
    .check_4   (check_4),
    .finished  (finished)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (check_r_en) ram_r_val <= mem[check_addr];

  function automatic void check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (finished) begin
      if (sb.size() == 0) check("unexpected_finished", 1, sb.size());
      else begin
        e = sb.pop_front();
        check("check_4_at_finished", int'(check_4), int'(e.win));
        check("finished_cycle", cyc, e.fin);
      end
    end
    if (check_r_en) begin
      check("read_addr", int'(check_addr), rd_idx);
      check("read_cycle", cyc - rd_base, 2 * rd_idx + 1);
      rd_idx++;
    end
  end

  task automatic load(input logic [15:0] r0, r1, r2, r3, r4, r5);
    mem[0] = r0; mem[1] = r1; mem[2] = r2; mem[3] = r3; mem[4] = r4; mem[5] = r5;
    mem[6] = 16'h0; mem[7] = 16'h0;
  endtask

  // returns #1 into the cycle after check_en was last sampled high
  task automatic go(input logic win, input int hold, input bit push);
    @(posedge clk); #1;
    rd_base = cyc;
    rd_idx  = 0;
    if (push) sb.push_back('{win, cyc + 13});
    check_en = 1'b1;
    repeat (hold) @(posedge clk);
    #1 check_en = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check("scan_timeout_pending", sb.size(), 0);
      sb.delete();
    end
    repeat (4) @(posedge clk);
  endtask

  task automatic scan(input logic [15:0] r0, r1, r2, r3, r4, r5, input logic win);
    load(r0, r1, r2, r3, r4, r5);
    go(win, 1, 1'b1);
    wait_done();
  endtask

  initial begin
    int n;
    load(16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_addr", int'(check_addr), 0);
    check("reset_r_en", int'(check_r_en), 0);
    check("reset_check_4", int'(check_4), 0);
    check("reset_finished", int'(finished), 0);
    rst = 1'b0;
    scan(16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    load(16'h0290, 16'h0090, 16'h0010, 16'h0010, 16'h0000, 16'h0000);
    go(1'b1, 5, 1'b1);
    wait_done();
    repeat (10) @(posedge clk);
    scan(16'h0055, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b1);
    scan(16'h0001, 16'h0004, 16'h0010, 16'h0040, 16'h0000, 16'h0000, 1'b1);
    scan(16'h0080, 16'h0020, 16'h0008, 16'h0002, 16'h0000, 16'h0000, 1'b1);
    scan(16'h0000, 16'h0000, 16'h1000, 16'h1000, 16'h1000, 16'h1000, 1'b1);
    scan(16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h1540, 1'b1);
    scan(16'h0015, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    scan(16'h0095, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    scan(16'hC000, 16'hC000, 16'hC000, 16'hC000, 16'hC000, 16'hC000, 1'b0);
    scan(16'h00FF, 16'h00FF, 16'h00FF, 16'h00FF, 16'h00FF, 16'h00FF, 1'b0);
    scan(16'h0010, 16'h0010, 16'h0010, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    // abort a winning scan with reset in cycle 6
    load(16'h0055, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    go(1'b1, 1, 1'b0);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_addr", int'(check_addr), 0);
    check("abort_r_en", int'(check_r_en), 0);
    check("abort_check_4", int'(check_4), 0);
    check("abort_finished", int'(finished), 0);
    rst = 1'b0;
    rd_idx = 6;
    repeat (20) @(posedge clk);
    scan(16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0055, 1'b1);
    // back-to-back: restart in the cycle right after finished
    load(16'h0055, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    go(1'b1, 1, 1'b1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!finished && n < 40);
    check("b2b_first_finished_seen", int'(finished), 1);
    @(posedge clk); #1;
    check("b2b_check_4_held", int'(check_4), 1);
    load(16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    rd_base = cyc;
    rd_idx  = 0;
    sb.push_back('{1'b0, cyc + 13});
    check_en = 1'b1;
    @(posedge clk); #1;
    check_en = 1'b0;
    check("b2b_check_4_cleared", int'(check_4), 0);
    wait_done();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
